// File: rtl/exec_sequencer_pkg.sv
// Shared opcode, ext-code, flag-index and state definitions for the fetch/execute sequencer.
// Also holds the opcode classification helpers used by decode and writeback.
package exec_sequencer_pkg;

   localparam logic [3:0] RTYPE  = 4'b0000;
   localparam logic [3:0] ADDI   = 4'b0101;
   localparam logic [3:0] SHIFTS = 4'b1000;
   localparam logic [3:0] SUBI   = 4'b1001;
   localparam logic [3:0] CMPI   = 4'b1011;

   localparam logic [3:0] EXT_AND  = 4'b0001;
   localparam logic [3:0] EXT_OR   = 4'b0010;
   localparam logic [3:0] EXT_XOR  = 4'b0011;
   localparam logic [3:0] EXT_ADD  = 4'b0101;
   localparam logic [3:0] EXT_CMP  = 4'b1011;
   localparam logic [3:0] EXT_LSHI = 4'b0000;
   localparam logic [3:0] EXT_LSH  = 4'b0100;

   localparam int CARRY_FLAG = 0;
   localparam int LOW_FLAG   = 1;
   localparam int FLAG_FLAG  = 2;
   localparam int ZERO_FLAG  = 3;

   localparam logic [4:0] TRAP_PSR = 5'b11111;

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      WRITEBACK = 3'd3,
      TRAP      = 3'd4
   } state_t;

   function automatic logic op_legal(input logic [3:0] op);
      return op inside {RTYPE, ADDI, SHIFTS, SUBI, CMPI};
   endfunction

   // Compares and undefined ext codes only update flags, never Rdest.
   function automatic logic writes_rdest(input logic [15:0] ir);
      logic we;
      we = 1'b0;
      case (ir[15:12])
         RTYPE:      we = ir[7:4] inside {EXT_ADD, EXT_OR, EXT_XOR, EXT_AND};
         SHIFTS:     we = ir[7:4] inside {EXT_LSH, EXT_LSHI};
         ADDI, SUBI: we = 1'b1;
         default:    we = 1'b0;
      endcase
      return we;
   endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Instruction fetch handshake and alu operand/result bundle between the sequencer and its
// neighbours (instruction memory, alu).
interface exec_sequencer_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_valid;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_opcode;
   logic [15:0] alu_c;
   logic [4:0]  alu_flags;

   modport master (
      output imem_req, imem_addr, alu_a, alu_b, alu_opcode,
      input  imem_rdata, imem_valid, alu_c, alu_flags
   );

   modport slave (
      input  imem_req, imem_addr, alu_a, alu_b, alu_opcode,
      output imem_rdata, imem_valid, alu_c, alu_flags
   );
endinterface

// File: rtl/regfile_16x16.sv
// Sixteen 16-bit registers: two operand read ports and a debug port (all combinational),
// one synchronous write port, asynchronous clear.
module regfile_16x16 (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  rd_a_sel,
   input  logic [3:0]  rd_b_sel,
   input  logic [3:0]  dbg_sel,
   output logic [15:0] rd_a,
   output logic [15:0] rd_b,
   output logic [15:0] dbg_data,
   input  logic        we,
   input  logic [3:0]  wr_sel,
   input  logic [15:0] wr_data
);

   logic [15:0] mem [16];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else if (we) begin
         mem[wr_sel] <= wr_data;
      end
   end

   assign rd_a     = mem[rd_a_sel];
   assign rd_b     = mem[rd_b_sel];
   assign dbg_data = mem[dbg_sel];

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller feeding an external 16-bit alu.
//
// state     | meaning
// FETCH     | imem_req high, waiting for imem_valid (timeout counter running)
// DECODE    | IR classified; illegal opcode traps
// EXECUTE   | operands settle through the alu
// WRITEBACK | psr <= flags, optional Rdest write, pc <= pc + 1
// TRAP      | halted until reset, trapped high
module exec_sequencer
   import exec_sequencer_pkg::*;
#(
   parameter logic [15:0] RESET_PC      = 16'h0000,
   parameter int          FETCH_TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               reset,
   exec_sequencer_if.master   bus,
   output logic [15:0]        pc,
   output logic [4:0]         psr,
   output logic               trapped,
   input  logic [3:0]         dbg_sel,
   output logic [15:0]        dbg_data
);

   state_t      state, state_nxt;
   logic [15:0] ir;
   logic [15:0] wait_cnt;
   logic        req_q;
   logic        fetch_fire;
   logic        fetch_wait;
   logic        timeout_hit;
   logic        illegal_hit;
   logic        rf_we;

   assign fetch_fire  = (state == FETCH) && req_q && bus.imem_valid;
   assign fetch_wait  = (state == FETCH) && req_q && !bus.imem_valid;
   assign timeout_hit = (FETCH_TIMEOUT != 0) && fetch_wait &&
                        (wait_cnt == 16'(FETCH_TIMEOUT - 1));
   assign illegal_hit = (state == DECODE) && !op_legal(ir[15:12]);
   assign rf_we       = (state == WRITEBACK) && writes_rdest(ir);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FETCH: begin
            if (fetch_fire)       state_nxt = DECODE;
            else if (timeout_hit) state_nxt = TRAP;
         end
         DECODE:    state_nxt = illegal_hit ? TRAP : EXECUTE;
         EXECUTE:   state_nxt = WRITEBACK;
         WRITEBACK: state_nxt = FETCH;
         TRAP:      state_nxt = TRAP;
         default:   state_nxt = TRAP;
      endcase
   end

   // req is registered so it rises one cycle after reset releases and drops right after acceptance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc       <= RESET_PC;
         ir       <= '0;
         psr      <= '0;
         wait_cnt <= '0;
         req_q    <= 1'b0;
      end else begin
         req_q <= (state_nxt == FETCH);
         if (fetch_fire) begin
            ir       <= bus.imem_rdata;
            wait_cnt <= '0;
         end else if (fetch_wait) begin
            wait_cnt <= wait_cnt + 16'd1;
         end
         if (illegal_hit || timeout_hit) psr <= TRAP_PSR;
         if (state == WRITEBACK) begin
            psr <= bus.alu_flags;
            pc  <= pc + 16'd1;
         end
      end
   end

   regfile_16x16 u_regfile (
      .clk      (clk),
      .reset    (reset),
      .rd_a_sel (ir[11:8]),
      .rd_b_sel (ir[3:0]),
      .dbg_sel  (dbg_sel),
      .rd_a     (bus.alu_a),
      .rd_b     (bus.alu_b),
      .dbg_data (dbg_data),
      .we       (rf_we),
      .wr_sel   (ir[11:8]),
      .wr_data  (bus.alu_c)
   );

   assign bus.imem_req   = req_q;
   assign bus.imem_addr  = pc;
   assign bus.alu_opcode = ir;
   assign trapped        = (state == TRAP);

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: two instances (default and wrap/timeout config)
// served by a behavioural instruction memory and a small alu stand-in.
module tb_exec_sequencer;
   import exec_sequencer_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   logic        rst1, rst2;
   logic [3:0]  dbg1, dbg2;
   logic [15:0] pc1, pc2, dbgd1, dbgd2;
   logic [4:0]  psr1, psr2;
   logic        trap1, trap2;

   exec_sequencer_if bus1 ();
   exec_sequencer_if bus2 ();

   exec_sequencer #(.RESET_PC(16'h0000), .FETCH_TIMEOUT(255)) dut1 (
      .clk(clk), .reset(rst1), .bus(bus1.master), .pc(pc1), .psr(psr1),
      .trapped(trap1), .dbg_sel(dbg1), .dbg_data(dbgd1)
   );

   exec_sequencer #(.RESET_PC(16'hFFFF), .FETCH_TIMEOUT(4)) dut2 (
      .clk(clk), .reset(rst2), .bus(bus2.master), .pc(pc2), .psr(psr2),
      .trapped(trap2), .dbg_sel(dbg2), .dbg_data(dbgd2)
   );

   // alu stand-in: returns {flags, c}; undefined ops give a marker result and no flags.
   function automatic logic [20:0] alu_f(input logic [15:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
      logic [15:0] simm, c;
      logic [4:0]  f;
      logic [16:0] s;
      simm = {{8{op[7]}}, op[7:0]};
      c = 16'hDEAD;
      f = '0;
      s = '0;
      case (op[15:12])
         RTYPE: begin
            case (op[7:4])
               EXT_ADD: begin
                  s = {1'b0, a} + {1'b0, b};
                  c = s[15:0];
                  f[CARRY_FLAG] = s[16];
                  f[FLAG_FLAG]  = (a[15] == b[15]) && (c[15] != a[15]);
                  f[ZERO_FLAG]  = (c == 16'h0);
               end
               EXT_AND: c = a & b;
               EXT_OR:  c = a | b;
               EXT_XOR: c = a ^ b;
               EXT_CMP: begin
                  c = 16'h0;
                  f[CARRY_FLAG] = (a < b);
                  f[LOW_FLAG]   = (a < b);
                  f[ZERO_FLAG]  = (a == b);
               end
               default: ;
            endcase
         end
         ADDI: begin
            s = {1'b0, a} + {1'b0, simm};
            c = s[15:0];
            f[CARRY_FLAG] = s[16];
            f[FLAG_FLAG]  = (a[15] == simm[15]) && (c[15] != a[15]);
            f[ZERO_FLAG]  = (c == 16'h0);
         end
         SUBI: begin
            c = a - simm;
            f[ZERO_FLAG] = (c == 16'h0);
         end
         CMPI: begin
            c = 16'h0;
            f[CARRY_FLAG] = (a < simm);
            f[LOW_FLAG]   = (a < simm);
            f[ZERO_FLAG]  = (a == simm);
         end
         SHIFTS: c = a << 1;
         default: ;
      endcase
      return {f, c};
   endfunction

   always_comb {bus1.alu_flags, bus1.alu_c} = alu_f(bus1.alu_opcode, bus1.alu_a, bus1.alu_b);
   always_comb {bus2.alu_flags, bus2.alu_c} = alu_f(bus2.alu_opcode, bus2.alu_a, bus2.alu_b);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reg1(input string tag, input logic [3:0] sel, input logic [15:0] exp);
      dbg1 = sel;
      #1;
      check_eq(tag, {16'h0, dbgd1}, {16'h0, exp});
   endtask

   // Waits (bounded) for a FETCH cycle with imem_req high on dut1.
   task automatic wait_req(output int t);
      int n;
      n = 0;
      while (bus1.imem_req !== 1'b1 && n < 32) begin
         @(negedge clk);
         n++;
      end
      check_eq("req_up", {31'h0, bus1.imem_req}, 32'h1);
      t = cyc;
   endtask

   // Serves one fetch on dut1 after 'delay' waiting cycles; returns in the DECODE cycle.
   task automatic serve(input logic [15:0] instr, input int delay, input logic [15:0] exp_addr,
                        output int t_start);
      wait_req(t_start);
      check_eq("fetch_addr", {16'h0, bus1.imem_addr}, {16'h0, exp_addr});
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         check_eq("addr_hold", {15'h0, bus1.imem_req, bus1.imem_addr}, {15'h0, 1'b1, exp_addr});
      end
      bus1.imem_valid = 1'b1;
      bus1.imem_rdata = instr;
      @(negedge clk);
      bus1.imem_valid = 1'b0;
      bus1.imem_rdata = 16'h0;
   endtask

   task automatic run(input logic [15:0] instr, input logic [15:0] exp_addr);
      int t0, t1;
      serve(instr, 0, exp_addr, t0);
      wait_req(t1);
      check_eq("run_cycles", t1 - t0, 32'd4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, t2, t3;
      rst1 = 1'b1;
      rst2 = 1'b1;
      dbg1 = 4'h0;
      dbg2 = 4'h0;
      bus1.imem_valid = 1'b0;
      bus1.imem_rdata = 16'h0;
      bus2.imem_valid = 1'b0;
      bus2.imem_rdata = 16'h0;
      repeat (2) @(negedge clk);

      check_eq("rst_pc", {16'h0, pc1}, 32'h0);
      check_eq("rst_req", {31'h0, bus1.imem_req}, 32'h0);
      check_eq("rst_trap", {31'h0, trap1}, 32'h0);
      check_eq("rst_psr", {27'h0, psr1}, 32'h0);
      check_eq("rst_opcode", {16'h0, bus1.alu_opcode}, 32'h0);
      rst1 = 1'b0;
      @(negedge clk);
      check_eq("req_after_rst", {31'h0, bus1.imem_req}, 32'h1);

      // R1=5, R2=3, R1=R1+R2 back to back
      serve({ADDI, 4'h1, 8'h05}, 0, 16'h0000, t0);
      serve({ADDI, 4'h2, 8'h03}, 0, 16'h0001, t1);
      check_eq("lat_addi", t1 - t0, 32'd4);
      serve({RTYPE, 4'h1, EXT_ADD, 4'h2}, 0, 16'h0002, t2);
      check_eq("lat_addi2", t2 - t1, 32'd4);
      wait_req(t3);
      check_eq("lat_add", t3 - t2, 32'd4);
      check_eq("pc_after3", {16'h0, pc1}, 32'h3);
      check_reg1("r1_sum", 4'h1, 16'h0008);
      check_reg1("r2_val", 4'h2, 16'h0003);
      check_eq("psr_add", {27'h0, psr1}, 32'h0);

      // three wait cycles, then spurious valid pulses during DECODE/EXECUTE
      serve({ADDI, 4'h3, 8'h01}, 3, 16'h0003, t0);
      bus1.imem_valid = 1'b1;
      bus1.imem_rdata = 16'hF000;
      @(negedge clk);
      @(negedge clk);
      bus1.imem_valid = 1'b0;
      bus1.imem_rdata = 16'h0;
      wait_req(t1);
      check_eq("lat_delay", t1 - t0, 32'd7);
      check_reg1("r3_val", 4'h3, 16'h0001);
      check_eq("no_spurious_trap", {31'h0, trap1}, 32'h0);
      check_eq("opcode_kept", {16'h0, bus1.alu_opcode}, {16'h0, ADDI, 4'h3, 8'h01});

      // reset during EXECUTE of ADDI R6,#9
      serve({ADDI, 4'h6, 8'h09}, 0, 16'h0004, t0);
      @(negedge clk);
      rst1 = 1'b1;
      @(negedge clk);
      check_eq("abort_pc", {16'h0, pc1}, 32'h0);
      check_eq("abort_req", {31'h0, bus1.imem_req}, 32'h0);
      check_reg1("abort_r6", 4'h6, 16'h0000);
      check_reg1("abort_r3", 4'h3, 16'h0000);
      rst1 = 1'b0;
      @(negedge clk);
      check_eq("abort_req_up", {31'h0, bus1.imem_req}, 32'h1);

      // compare, undefined ext, compare, OR
      run({ADDI, 4'h1, 8'h02}, 16'h0000);
      run({ADDI, 4'h2, 8'h07}, 16'h0001);
      run({RTYPE, 4'h1, EXT_CMP, 4'h2}, 16'h0002);
      check_reg1("cmp_r1", 4'h1, 16'h0002);
      check_eq("cmp_psr", {27'h0, psr1}, 32'h03);
      run({RTYPE, 4'h1, 4'hE, 4'h2}, 16'h0003);
      check_reg1("undef_r1", 4'h1, 16'h0002);
      check_eq("undef_psr", {27'h0, psr1}, 32'h0);
      run({RTYPE, 4'h1, EXT_CMP, 4'h2}, 16'h0004);
      check_eq("cmp2_psr", {27'h0, psr1}, 32'h03);
      run({RTYPE, 4'h1, EXT_OR, 4'h2}, 16'h0005);
      check_eq("or_psr", {27'h0, psr1}, 32'h0);
      check_reg1("or_r1", 4'h1, 16'h0007);
      check_eq("pc_before_ill", {16'h0, pc1}, 32'h6);

      // illegal opcode traps; fetch traffic is ignored afterwards
      serve(16'hF000, 0, 16'h0006, t0);
      repeat (3) @(negedge clk);
      bus1.imem_valid = 1'b1;
      bus1.imem_rdata = {ADDI, 4'h1, 8'h01};
      repeat (3) @(negedge clk);
      check_eq("ill_trap", {31'h0, trap1}, 32'h1);
      check_eq("ill_psr", {27'h0, psr1}, 32'h1F);
      check_eq("ill_req", {31'h0, bus1.imem_req}, 32'h0);
      check_eq("ill_pc", {16'h0, pc1}, 32'h6);
      check_reg1("ill_r1", 4'h1, 16'h0007);
      bus1.imem_valid = 1'b0;
      bus1.imem_rdata = 16'h0;
      rst1 = 1'b1;
      @(negedge clk);
      check_eq("trap_exit", {31'h0, trap1}, 32'h0);
      rst1 = 1'b0;

      // second instance: pc wrap then fetch timeout
      rst2 = 1'b0;
      begin
         int n;
         n = 0;
         @(negedge clk);
         while (bus2.imem_req !== 1'b1 && n < 32) begin
            @(negedge clk);
            n++;
         end
      end
      check_eq("w_req", {31'h0, bus2.imem_req}, 32'h1);
      check_eq("w_addr", {16'h0, bus2.imem_addr}, 32'hFFFF);
      bus2.imem_valid = 1'b1;
      bus2.imem_rdata = {ADDI, 4'h1, 8'h01};
      @(negedge clk);
      bus2.imem_valid = 1'b0;
      bus2.imem_rdata = 16'h0;
      repeat (3) @(negedge clk);
      check_eq("wrap_pc", {16'h0, pc2}, 32'h0);
      dbg2 = 4'h1;
      #1;
      check_eq("wrap_r1", {16'h0, dbgd2}, 32'h1);
      check_eq("wrap_req", {31'h0, bus2.imem_req}, 32'h1);
      repeat (3) @(negedge clk);
      check_eq("to_not_yet", {31'h0, trap2}, 32'h0);
      @(negedge clk);
      check_eq("to_trap", {31'h0, trap2}, 32'h1);
      check_eq("to_psr", {27'h0, psr2}, 32'h1F);
      check_eq("to_pc", {16'h0, pc2}, 32'h0);
      check_eq("to_req", {31'h0, bus2.imem_req}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
